// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl
//   Sequencer/arbiter that shares a byte-wide, combinationally-read
//   instruction RAM between the fetch stage and the program loader.
//   A fetch reads four sequential bytes from a word-aligned base and returns
//   them big-endian as one 32-bit word. A loader write is a single-cycle
//   byte write.
//
// Parameters
//   ADDR_W   RAM byte-address width (depth 2**ADDR_W)
//   ARB_MODE 0: loader has fixed priority, 1: round-robin on conflict
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   fetch_req/fetch_addr         fetch request (level) and byte address
//   fetch_busy                   high whenever the sequencer is not idle
//   fetch_valid/fetch_data       one-cycle response pulse, held data word
//   fetch_err                    (optional) out-of-range response flag
//   load_valid/addr/data         loader byte-write request
//   load_ready                   combinational; the write commits this edge
//   mem_addr/wdata/we/rdata      RAM interface
//
// Optional feature
//   `define INST_MEM_CTRL_RANGE_CHK_EN adds fetch_err. A fetch whose address
//   has any bit set at or above ADDR_W then skips the RAM and returns
//   data 0 with fetch_err = 1.
module inst_mem_ctrl #(
   parameter int ADDR_W   = 8,
   parameter int ARB_MODE = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_busy,
   output logic              fetch_valid,
   output logic [31:0]       fetch_data,
`ifdef INST_MEM_CTRL_RANGE_CHK_EN
   output logic              fetch_err,
`endif
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   output logic              load_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_e;

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-3:0] base_q, base_d;     // word index; byte offset is cnt
   logic [23:0]       asm_q, asm_d;       // first three bytes of the word
   logic [31:0]       data_q, data_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              last_load_q, last_load_d;  // 1 = loader granted last

   logic grant_load, grant_fetch, addr_oor;

`ifdef INST_MEM_CTRL_RANGE_CHK_EN
   assign addr_oor  = (fetch_addr >> ADDR_W) != 32'd0;
   assign fetch_err = err_q;
   logic unused_ok;
   assign unused_ok = ^fetch_addr[1:0];
`else
   // Upper address bits alias onto the RAM.
   assign addr_oor = 1'b0;
   logic unused_ok;
   assign unused_ok = ^{fetch_addr[31:ADDR_W], fetch_addr[1:0], err_q};
`endif

   // Arbitration happens only in IDLE; grants are mutually exclusive.
   always_comb begin
      grant_load  = 1'b0;
      grant_fetch = 1'b0;
      if (state_q == S_IDLE) begin
         if (load_valid && fetch_req) begin
            if (ARB_MODE == 0) begin
               grant_load = 1'b1;
            end else begin
               grant_load  = !last_load_q;
               grant_fetch = last_load_q;
            end
         end else begin
            grant_load  = load_valid;
            grant_fetch = fetch_req;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_fetch) state_d = addr_oor ? S_RESP : S_READ;
         S_READ:  if (cnt_q == 2'd3) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      cnt_d       = cnt_q;
      base_d      = base_q;
      asm_d       = asm_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      last_load_d = last_load_q;
      if (grant_load)  last_load_d = 1'b1;
      if (grant_fetch) begin
         last_load_d = 1'b0;
         base_d      = fetch_addr[ADDR_W-1:2];
         cnt_d       = 2'd0;
         if (addr_oor) begin
            data_d  = 32'd0;
            valid_d = 1'b1;
            err_d   = 1'b1;
         end
      end
      if (state_q == S_READ) begin
         cnt_d = cnt_q + 2'd1;
         case (cnt_q)
            2'd0: asm_d[23:16] = mem_rdata;
            2'd1: asm_d[15:8]  = mem_rdata;
            2'd2: asm_d[7:0]   = mem_rdata;
            default: begin
               // Publish the whole word at once so fetch_data only changes
               // together with fetch_valid.
               data_d  = {asm_q, mem_rdata};
               valid_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= 2'd0;
         base_q      <= '0;
         asm_q       <= 24'd0;
         data_q      <= 32'd0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         last_load_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         base_q      <= base_d;
         asm_q       <= asm_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         last_load_q <= last_load_d;
      end
   end

   // Outputs
   always_comb begin
      fetch_busy  = (state_q != S_IDLE);
      fetch_valid = valid_q;
      fetch_data  = data_q;
      load_ready  = grant_load;
      mem_we      = grant_load;
      mem_wdata   = grant_load ? load_data : 8'd0;
      mem_addr    = '0;
      if (grant_load)             mem_addr = load_addr;
      else if (state_q == S_READ) mem_addr = {base_q, cnt_q};
   end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
module tb_inst_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   always #5 clk = ~clk;

   // Main DUT (fixed loader priority)
   logic        fetch_req, fetch_busy, fetch_valid;
   logic [31:0] fetch_addr, fetch_data;
   logic        load_valid, load_ready, mem_we;
   logic [7:0]  load_addr, load_data, mem_addr, mem_wdata, mem_rdata;
`ifdef INST_MEM_CTRL_RANGE_CHK_EN
   logic        fetch_err, r_fetch_err;
`endif

   // Round-robin DUT
   logic        r_fetch_req, r_fetch_busy, r_fetch_valid;
   logic [31:0] r_fetch_addr, r_fetch_data;
   logic        r_load_valid, r_load_ready, r_mem_we;
   logic [7:0]  r_load_addr, r_load_data, r_mem_addr, r_mem_wdata, r_mem_rdata;

   inst_mem_ctrl #(.ADDR_W(8), .ARB_MODE(0)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_busy(fetch_busy),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data),
`ifdef INST_MEM_CTRL_RANGE_CHK_EN
      .fetch_err(fetch_err),
`endif
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
      .load_ready(load_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   inst_mem_ctrl #(.ADDR_W(8), .ARB_MODE(1)) u_rr (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(r_fetch_req), .fetch_addr(r_fetch_addr), .fetch_busy(r_fetch_busy),
      .fetch_valid(r_fetch_valid), .fetch_data(r_fetch_data),
`ifdef INST_MEM_CTRL_RANGE_CHK_EN
      .fetch_err(r_fetch_err),
`endif
      .load_valid(r_load_valid), .load_addr(r_load_addr), .load_data(r_load_data),
      .load_ready(r_load_ready), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
      .mem_we(r_mem_we), .mem_rdata(r_mem_rdata)
   );

   // RAM behind the main DUT; ref_mem is the bench's own view of its contents
   logic [7:0] ram [256];
   logic [7:0] ref_mem [256];
   assign mem_rdata   = ram[mem_addr];
   assign r_mem_rdata = r_mem_addr;
   always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

   typedef struct packed { logic [31:0] data; logic err; } exp_t;
   exp_t exp_q[$];
   exp_t m_e;
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endfunction

   // Response monitor / scoreboard
   always @(negedge clk) begin
      if (reset_n && fetch_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_valid: got data %h expected no response", fetch_data);
         end else begin
            m_e = exp_q.pop_front();
            chk("fetch_data", fetch_data, m_e.data);
`ifdef INST_MEM_CTRL_RANGE_CHK_EN
            chk("fetch_err", 32'(fetch_err), 32'(m_e.err));
`endif
         end
      end
   end

   // Called just after a posedge.
   task automatic do_load(input logic [7:0] a, input logic [7:0] d);
      int t = 0;
      load_valid = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      while (!load_ready && t < 20) begin @(negedge clk); t++; end
      if (!load_ready) begin
         n_cmp++; n_err++;
         $display("FAIL load_timeout: got no load_ready expected grant");
      end else begin
         chk("load_mem_addr", 32'(mem_addr), 32'(a));
         chk("load_wdata", 32'(mem_wdata), 32'(d));
         chk("load_we", 32'(mem_we), 32'd1);
      end
      @(posedge clk);
      ref_mem[a] = d;
      #1 load_valid = 1'b0;
   endtask

   // fetch_req/fetch_addr already driven, DUT idle, no competing load.
   // Optionally injects a loader write while the fetch is in READ.
   task automatic fetch_run(input logic [31:0] a, input bit inj,
                            input logic [7:0] la, input logic [7:0] ld);
      bit         oor;
      logic [7:0] b;
      exp_t       e;
`ifdef INST_MEM_CTRL_RANGE_CHK_EN
      oor = (a[31:8] != 24'h0);
`else
      oor = 1'b0;
`endif
      b = {a[7:2], 2'b00};
      e.err  = oor;
      e.data = oor ? 32'd0 : {ref_mem[b], ref_mem[b + 8'd1], ref_mem[b + 8'd2], ref_mem[b + 8'd3]};
      @(negedge clk);
      chk("pre_accept_busy", 32'(fetch_busy), 32'd0);
      exp_q.push_back(e);
      @(posedge clk);
      #1 fetch_req = 1'b0;
      if (!oor) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rd_addr", 32'(mem_addr), 32'(b + 8'(k)));
            chk("rd_busy", 32'(fetch_busy), 32'd1);
            chk("rd_valid", 32'(fetch_valid), 32'd0);
            chk("rd_load_ready", 32'(load_ready), 32'd0);
            if (inj && k == 1) begin
               load_valid = 1'b1; load_addr = la; load_data = ld;
            end
         end
      end
      @(negedge clk);
      chk("resp_valid", 32'(fetch_valid), 32'd1);
      chk("resp_busy", 32'(fetch_busy), 32'd1);
      chk("resp_load_ready", 32'(load_ready), 32'd0);
      chk("resp_mem_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      chk("post_valid", 32'(fetch_valid), 32'd0);
      chk("post_busy", 32'(fetch_busy), 32'd0);
      chk("held_data", fetch_data, e.data);
      if (inj) begin
         chk("late_load_ready", 32'(load_ready), 32'd1);
         chk("late_load_addr", 32'(mem_addr), 32'(la));
         @(posedge clk);
         ref_mem[la] = ld;
         #1 load_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_fetch(input logic [31:0] a);
      fetch_req = 1'b1; fetch_addr = a;
      fetch_run(a, 1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      logic [31:0] a;
      int          busy_left;
      bit          last_load;
      logic        exp_lr;
      fetch_req = 0; fetch_addr = 0; load_valid = 0; load_addr = 0; load_data = 0;
      r_fetch_req = 0; r_fetch_addr = 0; r_load_valid = 0; r_load_addr = 0; r_load_data = 0;
      reset_n = 1'b0;
      #12;
      chk("rst_busy", 32'(fetch_busy), 32'd0);
      chk("rst_valid", 32'(fetch_valid), 32'd0);
      chk("rst_data", fetch_data, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(posedge clk); #1;

      // Fill the whole RAM so the model and RAM agree everywhere
      for (int i = 0; i < 256; i++) do_load(8'(i), 8'($urandom));

      // Directed big-endian assembly
      do_load(8'd0, 8'h12); do_load(8'd1, 8'h34); do_load(8'd2, 8'h56); do_load(8'd3, 8'h78);
      do_fetch(32'h0);
      chk("word0_const", fetch_data, 32'h12345678);
      do_load(8'd4, 8'hE3); do_load(8'd5, 8'hA0); do_load(8'd6, 8'h10); do_load(8'd7, 8'h05);
      do_fetch(32'h6);
      chk("word1_aligned", fetch_data, 32'hE3A01005);

      // Conflict in IDLE: loader wins, fetch follows and sees the new byte
      load_valid = 1'b1; load_addr = 8'd9; load_data = 8'hA5;
      fetch_req = 1'b1; fetch_addr = 32'h8;
      @(negedge clk);
      chk("conflict_load_ready", 32'(load_ready), 32'd1);
      chk("conflict_busy", 32'(fetch_busy), 32'd0);
      @(posedge clk);
      ref_mem[9] = 8'hA5;
      #1 load_valid = 1'b0;
      fetch_run(32'h8, 1'b0, 8'h00, 8'h00);

      // Loader request during READ, targeting the word being fetched
      fetch_req = 1'b1; fetch_addr = 32'h4;
      fetch_run(32'h4, 1'b1, 8'd5, 8'h5A);
      do_fetch(32'h4);
      chk("late_write_seen", fetch_data, {8'hE3, 8'h5A, 8'h10, 8'h05});

      // Reset in READ with cnt = 2
      fetch_req = 1'b1; fetch_addr = 32'h0;
      @(posedge clk); #1 fetch_req = 1'b0;
      @(posedge clk); @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(fetch_busy), 32'd0);
      chk("midrst_valid", 32'(fetch_valid), 32'd0);
      chk("midrst_data", fetch_data, 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(posedge clk); #1;
      do_fetch(32'h0);
      chk("after_rst_word", fetch_data, 32'h12345678);

`ifdef INST_MEM_CTRL_RANGE_CHK_EN
      do_fetch(32'h100);
      do_fetch(32'h0);
`endif

      // Randomized mix of loads and fetches (including aliased addresses)
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            do_load(8'($urandom), 8'($urandom));
         end else begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = {24'h0, a[7:0]};
            fetch_req = 1'b1; fetch_addr = a;
            fetch_run(a, ($urandom_range(0, 4) == 0), 8'($urandom), 8'($urandom));
         end
      end

      // Round-robin: both held high, grants alternate load, fetch, load, ...
      r_load_valid = 1'b1; r_load_addr = 8'h10; r_fetch_req = 1'b1; r_fetch_addr = 32'h0;
      busy_left = 0; last_load = 1'b0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         chk("rr_busy", 32'(r_fetch_busy), 32'(busy_left > 0));
         if (busy_left > 0) begin
            exp_lr = 1'b0; busy_left--;
         end else if (!last_load) begin
            exp_lr = 1'b1; last_load = 1'b1;
         end else begin
            exp_lr = 1'b0; last_load = 1'b0; busy_left = 5;
         end
         chk("rr_load_ready", 32'(r_load_ready), 32'(exp_lr));
      end
      r_load_valid = 1'b0; r_fetch_req = 1'b0;

      // Drain any outstanding response
      for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
